// File: rtl/adder_arbiter_pkg.sv
// Shared constants and helpers for the round-robin adder arbiter.
package adder_arbiter_pkg;

  // Width of the shared adder; operand width is tied to it.
  localparam int unsigned AdderW = 5;

  // Default number of requesters sharing the adder.
  localparam int unsigned DefaultNreq = 4;

  // Width of the saturating accepted-request counter.
  localparam int unsigned GrantCntW = 8;

  localparam logic [GrantCntW-1:0] GrantCntMax = '1;

  // Saturating increment for the grant counter.
  function automatic logic [GrantCntW-1:0] sat_inc(input logic [GrantCntW-1:0] v);
    return (v == GrantCntMax) ? v : v + GrantCntW'(1);
  endfunction

endpackage

// File: rtl/adder_arbiter_adder.sv
// Shared unsigned adder: {cout, sum} = a + b, no carry-in.
module adder_arbiter_adder
  import adder_arbiter_pkg::*;
(
  input  logic [AdderW-1:0] a,
  input  logic [AdderW-1:0] b,
  output logic [AdderW-1:0] sum,
  output logic              cout
);

  logic [AdderW:0] full_sum;

  // Widen by one bit so the carry falls out of the same addition.
  always_comb begin
    full_sum = {1'b0, a} + {1'b0, b};
  end

  assign sum  = full_sum[AdderW-1:0];
  assign cout = full_sum[AdderW];

endmodule

// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one adder among NREQ requesters, with a
// single registered result slot that supports one result per cycle.
module adder_arbiter
  import adder_arbiter_pkg::*;
#(
  parameter int unsigned NREQ = DefaultNreq,
  parameter int unsigned W    = AdderW
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*W-1:0]        req_a,
  input  logic [NREQ*W-1:0]        req_b,
  output logic [NREQ-1:0]          req_ready,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [W-1:0]             rsp_sum,
  output logic                     rsp_cout,
  output logic [$clog2(NREQ)-1:0]  rsp_id,
  output logic [GrantCntW-1:0]     grant_cnt
);

  localparam int unsigned IdxW = $clog2(NREQ);
  localparam logic [IdxW:0] NreqL = (IdxW+1)'(NREQ);

  logic [IdxW-1:0]      rr_ptr_q, rr_ptr_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [W-1:0]         rsp_sum_q, rsp_sum_d;
  logic                 rsp_cout_q, rsp_cout_d;
  logic [IdxW-1:0]      rsp_id_q, rsp_id_d;
  logic [GrantCntW-1:0] grant_cnt_q, grant_cnt_d;

  logic                 slot_free;
  logic [2*NREQ-1:0]    req_dbl;
  logic [NREQ-1:0]      req_rot;
  logic                 found;
  logic [IdxW-1:0]      grant_off;
  logic [IdxW:0]        idx_sum;
  logic [IdxW:0]        idx_wrap;
  logic [IdxW-1:0]      grant_idx;
  logic                 transfer;
  logic [IdxW:0]        rr_inc;

  logic [W-1:0]         a_sel, b_sel;
  logic [W-1:0]         add_sum;
  logic                 add_cout;

  // A new result may be loaded when the slot is empty or drains this cycle.
  assign slot_free = ~rsp_valid_q | rsp_ready;

  // Rotate requests so bit 0 is the requester at rr_ptr.
  assign req_dbl = {req_valid, req_valid} >> rr_ptr_q;
  assign req_rot = req_dbl[NREQ-1:0];

  // Priority search over the rotated vector, then map back to an index.
  always_comb begin
    found     = 1'b0;
    grant_off = '0;
    for (int k = 0; k < int'(NREQ); k++) begin
      if (!found && req_rot[k]) begin
        found     = 1'b1;
        grant_off = IdxW'(k);
      end
    end
    idx_sum  = {1'b0, rr_ptr_q} + {1'b0, grant_off};
    idx_wrap = idx_sum - NreqL;
    grant_idx = (idx_sum >= NreqL) ? idx_wrap[IdxW-1:0] : idx_sum[IdxW-1:0];
  end

  // One-hot grant; forced low while in reset so it never depends on clk.
  always_comb begin
    req_ready = '0;
    if (rst_n && slot_free && found) begin
      req_ready = NREQ'(1) << grant_idx;
    end
  end

  assign transfer = |(req_valid & req_ready);

  // Operand mux feeding the single shared adder.
  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (grant_idx == IdxW'(i)) begin
        a_sel = req_a[i*W +: W];
        b_sel = req_b[i*W +: W];
      end
    end
  end

  adder_arbiter_adder u_adder (
    .a    (a_sel),
    .b    (b_sel),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // Next-state for the result slot, round-robin pointer and grant counter.
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_sum_d   = rsp_sum_q;
    rsp_cout_d  = rsp_cout_q;
    rsp_id_d    = rsp_id_q;
    rr_ptr_d    = rr_ptr_q;
    grant_cnt_d = grant_cnt_q;
    rr_inc      = {1'b0, grant_idx} + (IdxW+1)'(1);
    if (transfer) begin
      rsp_valid_d = 1'b1;
      rsp_sum_d   = add_sum;
      rsp_cout_d  = add_cout;
      rsp_id_d    = grant_idx;
      rr_ptr_d    = (rr_inc == NreqL) ? '0 : rr_inc[IdxW-1:0];
      grant_cnt_d = sat_inc(grant_cnt_q);
    end else if (rsp_ready) begin
      // Drain without refill: payload is kept, only valid drops.
      rsp_valid_d = 1'b0;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_sum_q   <= '0;
      rsp_cout_q  <= 1'b0;
      rsp_id_q    <= '0;
      grant_cnt_q <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_sum_q   <= rsp_sum_d;
      rsp_cout_q  <= rsp_cout_d;
      rsp_id_q    <= rsp_id_d;
      grant_cnt_q <= grant_cnt_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_sum   = rsp_sum_q;
  assign rsp_cout  = rsp_cout_q;
  assign rsp_id    = rsp_id_q;
  assign grant_cnt = grant_cnt_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// Self-checking bench for adder_arbiter (NREQ=4, W=5) with a result scoreboard.
module tb_adder_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [19:0] req_a;
  logic [19:0] req_b;
  logic [3:0]  req_ready;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [4:0]  rsp_sum;
  logic        rsp_cout;
  logic [1:0]  rsp_id;
  logic [7:0]  grant_cnt;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [4:0] sum;
    logic       cout;
    logic [1:0] id;
  } exp_t;

  exp_t sb[$];
  exp_t last;

  // Reference model state
  logic [1:0] m_rr;
  logic       m_valid;
  logic [7:0] m_cnt;

  adder_arbiter #(.NREQ(4), .W(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout),
    .rsp_id    (rsp_id),
    .grant_cnt (grant_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] model_ready();
    int idx;
    if (m_valid && !rsp_ready) return 4'b0000;
    for (int k = 0; k < 4; k++) begin
      idx = (int'(m_rr) + k) % 4;
      if (req_valid[idx]) return 4'b0001 << idx;
    end
    return 4'b0000;
  endfunction

  task automatic set_op(input int i, input logic [4:0] a, input logic [4:0] b);
    req_a[i*5 +: 5] = a;
    req_b[i*5 +: 5] = b;
  endtask

  // Advance one clock, updating the model and pushing any expected result.
  task automatic tick();
    logic [3:0] rdy;
    logic [5:0] s6;
    exp_t       e;
    int         g;
    rdy = model_ready();
    g   = -1;
    e   = '0;
    for (int i = 0; i < 4; i++) begin
      if (rdy[i] && req_valid[i]) begin
        g      = i;
        s6     = {1'b0, req_a[i*5 +: 5]} + {1'b0, req_b[i*5 +: 5]};
        e.sum  = s6[4:0];
        e.cout = s6[5];
        e.id   = 2'(i);
      end
    end
    @(posedge clk);
    if (g >= 0) begin
      sb.push_back(e);
      last    = e;
      m_valid = 1'b1;
      m_rr    = 2'((g + 1) % 4);
      if (m_cnt != 8'd255) m_cnt = m_cnt + 8'd1;
    end else if (rsp_ready) begin
      m_valid = 1'b0;
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = 4'b0000;
    rsp_ready = 1'b0;
    m_rr      = 2'd0;
    m_valid   = 1'b0;
    m_cnt     = 8'd0;
    sb.delete();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    req_a     = '0;
    req_b     = '0;
    #2;
    checks++; if (rsp_valid !== 1'b0) begin errors++;
      $display("FAIL reset_valid: got %b want 0", rsp_valid); end
    checks++; if (rsp_sum !== 5'd0 || rsp_cout !== 1'b0 || rsp_id !== 2'd0) begin errors++;
      $display("FAIL reset_payload: got %h/%b/%0d want 0/0/0", rsp_sum, rsp_cout, rsp_id); end
    checks++; if (grant_cnt !== 8'd0) begin errors++;
      $display("FAIL reset_cnt: got %0d want 0", grant_cnt); end
    checks++; if (req_ready !== 4'b0000) begin errors++;
      $display("FAIL reset_ready: got %b want 0000", req_ready); end
    do_reset();
  endtask

  task automatic test_single();
    exp_t e;
    set_op(0, 5'd7, 5'd9);
    req_valid = 4'b0001;
    rsp_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++;
      $display("FAIL single_ready: got %b want 0001", req_ready); end
    tick();
    req_valid = 4'b0000;
    checks++; if (rsp_valid !== 1'b1 || sb.size() == 0) begin errors++;
      $display("FAIL single_valid: got %b want 1", rsp_valid); end
    else begin
      e = sb.pop_front();
      checks++; if ({rsp_sum, rsp_cout, rsp_id} !== e) begin errors++;
        $display("FAIL single_sb: got %h want %h", {rsp_sum, rsp_cout, rsp_id}, e); end
    end
    checks++; if (rsp_sum !== 5'd16 || rsp_cout !== 1'b0 || rsp_id !== 2'd0) begin errors++;
      $display("FAIL single_const: got %0d/%b/%0d want 16/0/0", rsp_sum, rsp_cout, rsp_id); end
    #1 tick();
    checks++; if (rsp_valid !== 1'b0 || rsp_sum !== last.sum || rsp_id !== last.id) begin errors++;
      $display("FAIL drain_hold: got v=%b s=%0d want v=0 s=%0d", rsp_valid, rsp_sum, last.sum); end
  endtask

  task automatic test_overflow();
    exp_t e;
    set_op(2, 5'd31, 5'd1);
    req_valid = 4'b0100;
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++;
      $display("FAIL ovf1_ready: got %b want 0100", req_ready); end
    tick();
    checks++; if (rsp_valid !== 1'b1 || sb.size() == 0) begin errors++;
      $display("FAIL ovf1_valid: got %b want 1", rsp_valid); end
    else begin
      e = sb.pop_front();
      checks++; if ({rsp_sum, rsp_cout, rsp_id} !== e) begin errors++;
        $display("FAIL ovf1_sb: got %h want %h", {rsp_sum, rsp_cout, rsp_id}, e); end
    end
    checks++; if (rsp_sum !== 5'd0 || rsp_cout !== 1'b1) begin errors++;
      $display("FAIL ovf1_const: got %0d/%b want 0/1", rsp_sum, rsp_cout); end
    // Back-to-back: drain and refill in the same cycle
    set_op(3, 5'd31, 5'd31);
    req_valid = 4'b1000;
    #1;
    checks++; if (req_ready !== 4'b1000) begin errors++;
      $display("FAIL ovf2_ready: got %b want 1000", req_ready); end
    tick();
    req_valid = 4'b0000;
    checks++; if (rsp_valid !== 1'b1 || sb.size() == 0) begin errors++;
      $display("FAIL ovf2_valid: got %b want 1", rsp_valid); end
    else begin
      e = sb.pop_front();
      checks++; if ({rsp_sum, rsp_cout, rsp_id} !== e) begin errors++;
        $display("FAIL ovf2_sb: got %h want %h", {rsp_sum, rsp_cout, rsp_id}, e); end
    end
    checks++; if (rsp_sum !== 5'd30 || rsp_cout !== 1'b1 || rsp_id !== 2'd3) begin errors++;
      $display("FAIL ovf2_const: got %0d/%b/%0d want 30/1/3", rsp_sum, rsp_cout, rsp_id); end
    #1 tick();
  endtask

  task automatic test_fairness();
    int   exp_g [5] = '{0, 1, 2, 3, 0};
    exp_t e;
    do_reset();
    for (int i = 0; i < 4; i++) set_op(i, 5'($urandom), 5'($urandom));
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++; if (req_ready !== (4'b0001 << exp_g[c])) begin errors++;
        $display("FAIL fair_grant%0d: got %b want %b", c, req_ready, 4'b0001 << exp_g[c]); end
      tick();
      checks++; if (rsp_valid !== 1'b1 || sb.size() == 0) begin errors++;
        $display("FAIL fair_valid%0d: got %b want 1", c, rsp_valid); end
      else begin
        e = sb.pop_front();
        checks++; if ({rsp_sum, rsp_cout, rsp_id} !== e) begin errors++;
          $display("FAIL fair_sb%0d: got %h want %h", c, {rsp_sum, rsp_cout, rsp_id}, e); end
      end
    end
    req_valid = 4'b0000;
    #1 tick();
  endtask

  task automatic test_backpressure();
    exp_t e;
    set_op(0, 5'($urandom), 5'($urandom));
    req_valid = 4'b0001;
    rsp_ready = 1'b1;
    #1 tick();
    if (sb.size() != 0) begin
      e = sb.pop_front();
      checks++; if ({rsp_sum, rsp_cout, rsp_id} !== e) begin errors++;
        $display("FAIL bp_first: got %h want %h", {rsp_sum, rsp_cout, rsp_id}, e); end
    end
    rsp_ready = 1'b0;
    req_valid = 4'b0110;
    set_op(1, 5'($urandom), 5'($urandom));
    set_op(2, 5'($urandom), 5'($urandom));
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (req_ready !== 4'b0000) begin errors++;
        $display("FAIL bp_ready%0d: got %b want 0000", c, req_ready); end
      checks++; if (rsp_valid !== 1'b1 || {rsp_sum, rsp_cout, rsp_id} !== last) begin errors++;
        $display("FAIL bp_hold%0d: got %b/%h want 1/%h", c, rsp_valid,
                 {rsp_sum, rsp_cout, rsp_id}, last); end
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++;
      $display("FAIL bp_release: got %b want 0010", req_ready); end
    tick();
    req_valid = 4'b0000;
    checks++; if (rsp_valid !== 1'b1 || sb.size() == 0) begin errors++;
      $display("FAIL bp_valid: got %b want 1", rsp_valid); end
    else begin
      e = sb.pop_front();
      checks++; if ({rsp_sum, rsp_cout, rsp_id} !== e || rsp_id !== 2'd1) begin errors++;
        $display("FAIL bp_sb: got %h want %h", {rsp_sum, rsp_cout, rsp_id}, e); end
    end
    #1 tick();
    checks++; if (rsp_valid !== 1'b0) begin errors++;
      $display("FAIL bp_drain: got %b want 0", rsp_valid); end
  endtask

  task automatic test_saturation();
    exp_t e;
    do_reset();
    for (int i = 0; i < 4; i++) set_op(i, 5'($urandom), 5'($urandom));
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    for (int n = 1; n <= 300; n++) begin
      #1 tick();
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL sat_missing%0d: got empty want result", n);
      end else begin
        e = sb.pop_front();
        checks++; if ({rsp_sum, rsp_cout, rsp_id} !== e) begin errors++;
          $display("FAIL sat_sb%0d: got %h want %h", n, {rsp_sum, rsp_cout, rsp_id}, e); end
      end
      set_op(int'(last.id), 5'($urandom), 5'($urandom));
      if (n == 254) begin
        checks++; if (grant_cnt !== 8'd254) begin errors++;
          $display("FAIL sat_254: got %0d want 254", grant_cnt); end
      end
      if (n == 256) begin
        checks++; if (grant_cnt !== 8'd255) begin errors++;
          $display("FAIL sat_256: got %0d want 255", grant_cnt); end
      end
    end
    checks++; if (grant_cnt !== 8'd255 || grant_cnt !== m_cnt) begin errors++;
      $display("FAIL sat_final: got %0d want 255", grant_cnt); end
    req_valid = 4'b0000;
    #1 tick();
  endtask

  task automatic test_reset_midflight();
    exp_t e;
    set_op(2, 5'($urandom), 5'($urandom));
    req_valid = 4'b0100;
    rsp_ready = 1'b1;
    #1 tick();
    rsp_ready = 1'b0;
    checks++; if (rsp_valid !== 1'b1) begin errors++;
      $display("FAIL mid_pending: got %b want 1", rsp_valid); end
    #1 rst_n = 1'b0;
    rsp_ready = 1'b1;
    req_valid = 4'b1111;
    #1;
    checks++; if (rsp_valid !== 1'b0 || req_ready !== 4'b0000) begin errors++;
      $display("FAIL mid_async: got v=%b r=%b want v=0 r=0000", rsp_valid, req_ready); end
    checks++; if (grant_cnt !== 8'd0 || rsp_sum !== 5'd0 || rsp_id !== 2'd0) begin errors++;
      $display("FAIL mid_clear: got cnt=%0d s=%0d id=%0d want 0/0/0", grant_cnt, rsp_sum, rsp_id); end
    m_rr    = 2'd0;
    m_valid = 1'b0;
    m_cnt   = 8'd0;
    sb.delete();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) set_op(i, 5'($urandom), 5'($urandom));
    req_valid = 4'b1010;
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++;
      $display("FAIL mid_first: got %b want 0010", req_ready); end
    tick();
    req_valid = 4'b0000;
    checks++; if (rsp_valid !== 1'b1 || sb.size() == 0) begin errors++;
      $display("FAIL mid_valid: got %b want 1", rsp_valid); end
    else begin
      e = sb.pop_front();
      checks++; if ({rsp_sum, rsp_cout, rsp_id} !== e || rsp_id !== 2'd1) begin errors++;
        $display("FAIL mid_sb: got %h want %h", {rsp_sum, rsp_cout, rsp_id}, e); end
    end
    checks++; if (grant_cnt !== 8'd1) begin errors++;
      $display("FAIL mid_cnt: got %0d want 1", grant_cnt); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_overflow();
    test_fairness();
    test_backpressure();
    test_saturation();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/adder_arbiter.md
ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001 The block SHALL have parameter NREQ, default 4, meaning number of requesters sharing one adder (2..8).
REQ-002 The block SHALL have parameter W, default 5, meaning operand width, fixed to the shared adder width.
REQ-003 The block SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 The block SHALL have port req_valid  input  NREQ  per-requester operand-valid.
REQ-006 The block SHALL have port req_a  input  NREQ*W  packed operand A; requester i at bits [i*W +: W].
REQ-007 The block SHALL have port req_b  input  NREQ*W  packed operand B, same packing.
REQ-008 The block SHALL have port req_ready  output  NREQ  one-hot grant; a transfer is req_valid[i] & req_ready[i].
REQ-009 The block SHALL have port rsp_valid  output  1  registered result valid.
REQ-010 The block SHALL have port rsp_ready  input  1  consumer accepts result.
REQ-011 The block SHALL have port rsp_sum  output  W  registered sum.
REQ-012 The block SHALL have port rsp_cout  output  1  registered carry-out.
REQ-013 The block SHALL have port rsp_id  output  clog2(NREQ)  index of the requester owning the result.
REQ-014 The block SHALL have port grant_cnt  output  8  saturating count of accepted requests since reset.

Function
REQ-015 The output slot SHALL be "free" when rsp_valid=0 or rsp_ready=1 in the same cycle.
REQ-016 When the slot is free, req_ready SHALL be one-hot on the first requester with req_valid set, searching from rr_ptr upward with wrap from NREQ-1 to 0; otherwise req_ready SHALL be all zeros.
REQ-017 req_ready SHALL depend combinationally only on req_valid, rr_ptr, rsp_valid and rsp_ready; never on operand values.
REQ-018 On a transfer from requester g, at the next edge rsp_sum/rsp_cout SHALL load the adder result of req_a[g]+req_b[g], rsp_id SHALL load g, and rsp_valid SHALL be 1 (latency one cycle).
REQ-019 On a transfer, rr_ptr SHALL load (g+1) mod NREQ; with no transfer rr_ptr SHALL hold.
REQ-020 When rsp_valid=1 and rsp_ready=1 and no transfer occurs, rsp_valid SHALL clear at the next edge; rsp_sum/rsp_cout/rsp_id SHALL hold.
REQ-021 When rsp_valid=1 and rsp_ready=0, all rsp_* outputs SHALL hold and req_ready SHALL be zero (backpressure).
REQ-022 Simultaneous drain and transfer in one cycle SHALL yield back-to-back results with rsp_valid remaining 1 (full throughput, one result per cycle).
REQ-023 Result arithmetic SHALL be unsigned: {rsp_cout, rsp_sum} = req_a[g] + req_b[g] modulo 2^(W+1); no carry-in.
REQ-024 grant_cnt SHALL increment by 1 on each transfer and saturate at 255.
REQ-025 A requester SHALL keep operands stable while req_valid is high and unserved; the block SHALL NOT latch operands before grant.

Reset
REQ-026 While rst_n=0: rsp_valid=0, rsp_sum=0, rsp_cout=0, rsp_id=0, rr_ptr=0, grant_cnt=0, req_ready=0, independent of clk.
REQ-027 Reset asserted mid-operation SHALL discard any pending result without a response; first grant after release SHALL start search at requester 0.

Structure
REQ-028 A shared package SHALL hold constants for W (5), default NREQ, and the grant_cnt width (8).
REQ-029 The block SHALL instantiate the team's existing 5-bit adder as its single sub-module, fed by a NREQ:1 operand mux selected by the grant index; no other arithmetic path SHALL exist.
REQ-030 The round-robin search SHALL be implemented as a priority search over a rotated request vector, not a per-NREQ case table.

Verification
REQ-031 Single request: req_valid=0001, a0=5'd7, b0=5'd9 -> req_ready=0001 same cycle; next cycle rsp_valid=1, rsp_sum=5'd16, rsp_cout=0, rsp_id=0.
REQ-032 Overflow: a=5'd31, b=5'd1 -> rsp_sum=0, rsp_cout=1; a=b=5'd31 -> rsp_sum=5'd30, rsp_cout=1.
REQ-033 Fairness: req_valid=1111 held, rsp_ready=1 -> grants 0,1,2,3,0 on consecutive cycles, rsp_valid continuously 1 from cycle 2.
REQ-034 Backpressure: result pending, rsp_ready=0 for 3 cycles with req_valid=0110 -> req_ready=0000, rsp_* stable; rsp_ready=1 -> grant requester 1 that cycle.
REQ-035 Saturation: 300 transfers -> grant_cnt=255.
REQ-036 Reset mid-flight: rst_n low while rsp_valid=1 -> rsp_valid=0 immediately; after release with req_valid=1010 -> first grant requester 1.
